// File: rtl/snes_frame_sync_ctrl.sv
// ---------------------------------------------------------------------------
// snes_frame_sync_ctrl
//
// Per-frame SNES/HDMI lock sequencer, clocked in the SNES clock domain.
// Once per frame it halts the SNES core during the DRAM refresh window of an
// early scanline. It holds the halt until a fresh HDMI frame-start edge
// arrives, or until a cycle timeout expires, and then releases the core.
// It also reports lock status and pause-length telemetry.
//
// Ports:
//   clk              SNES system clock
//   reset            asynchronous, active-high reset
//   enable           1 = frame sync active, 0 = free-run (never pause)
//   ys[8:0]          {field, scanline}; only the scanline byte is used
//   snes_refresh     SNES DRAM refresh window (level)
//   hdmi_frame_start level from the pixel clock domain, held >= 2 clk periods
//   pause_snes       registered halt request to the SNES core
//   sync_locked      1 after an HDMI-released pause, 0 after timeout/disable
//   pause_len[19:0]  cycles pause_snes was high in the last completed pause
//   timeout_count    saturating count of pauses ended by timeout
// ---------------------------------------------------------------------------
module snes_frame_sync_ctrl #(
  parameter int unsigned PAUSE_LINE     = 2,
  parameter int unsigned REARM_LINE     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 400000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  ys,
  input  logic        snes_refresh,
  input  logic        hdmi_frame_start,
  output logic        pause_snes,
  output logic        sync_locked,
  output logic [19:0] pause_len,
  output logic [7:0]  timeout_count
);

  localparam logic [7:0]  PAUSE_Y  = 8'(PAUSE_LINE);
  localparam logic [7:0]  REARM_Y  = 8'(REARM_LINE);
  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] CNT_FULL = 20'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    PAUSED = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [19:0]            cnt;
  logic [19:0]            cnt_nx;
  logic                   pause_nx;
  logic                   locked_nx;
  logic [19:0]            len_nx;
  logic [7:0]             tcnt_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   fs_prev;
  logic                   fs_rise;
  logic                   ys_field_unused;

  // The field bit does not take part in line matching.
  assign ys_field_unused = ys[8];

  // Synchronize the HDMI frame-start level and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      fs_prev <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], hdmi_frame_start};
      fs_prev <= sync[SYNC_STAGES-1];
    end
  end

  // Only a fresh rising edge counts. The edge is never latched, so an edge seen
  // outside PAUSED is simply lost and cannot release a later pause.
  assign fs_rise = sync[SYNC_STAGES-1] & ~fs_prev;

  // Next-state and next-output logic; disable overrides every other transition
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pause_nx  = pause_snes;
    locked_nx = sync_locked;
    len_nx    = pause_len;
    tcnt_nx   = timeout_count;
    if (!enable) begin
      state_nx  = IDLE;
      pause_nx  = 1'b0;
      locked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ARMED;
          pause_nx = 1'b0;
        end
        ARMED: begin
          if ((ys[7:0] == PAUSE_Y) && snes_refresh) begin
            state_nx = PAUSED;
            pause_nx = 1'b1;
            cnt_nx   = 20'd0;
          end else begin
            state_nx = ARMED;
          end
        end
        PAUSED: begin
          // cnt lags the number of high cycles by one, so the release edge
          // reports cnt+1 as the exact length of the pause.
          cnt_nx = cnt + 20'd1;
          if (fs_rise) begin
            state_nx  = RUN;
            pause_nx  = 1'b0;
            len_nx    = cnt + 20'd1;
            locked_nx = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nx  = RUN;
            pause_nx  = 1'b0;
            len_nx    = CNT_FULL;
            locked_nx = 1'b0;
            if (timeout_count == 8'hFF) begin
              tcnt_nx = timeout_count;
            end else begin
              tcnt_nx = timeout_count + 8'd1;
            end
          end else begin
            state_nx = PAUSED;
          end
        end
        RUN: begin
          pause_nx = 1'b0;
          if (ys[7:0] == REARM_Y) begin
            state_nx = ARMED;
          end else begin
            state_nx = RUN;
          end
        end
        default: begin
          state_nx  = IDLE;
          pause_nx  = 1'b0;
          locked_nx = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 20'd0;
      pause_snes    <= 1'b0;
      sync_locked   <= 1'b0;
      pause_len     <= 20'd0;
      timeout_count <= 8'd0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pause_snes    <= pause_nx;
      sync_locked   <= locked_nx;
      pause_len     <= len_nx;
      timeout_count <= tcnt_nx;
    end
  end

endmodule

// File: tb/tb_snes_frame_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snes_frame_sync_ctrl
//
// Self-checking bench. A timestamp-based reference model predicts every
// output each cycle. The HDMI synchronizer is modelled as a delayed sample
// history, and pause length as the difference of edge indices. Directed
// sequences cover the listed scenarios, and a random phase follows them.
// ---------------------------------------------------------------------------
module tb_snes_frame_sync_ctrl;

  localparam int T  = 100;
  localparam int S  = 2;
  localparam int PL = 2;
  localparam int RL = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  ys;
  logic        snes_refresh;
  logic        hdmi_frame_start;
  logic        pause_snes;
  logic        sync_locked;
  logic [19:0] pause_len;
  logic [7:0]  timeout_count;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_active;
  bit m_armed;
  bit m_halted;
  bit m_locked;
  int m_edge;
  int m_start;
  int m_len;
  int m_tcnt;
  bit hist[$];

  snes_frame_sync_ctrl #(
    .PAUSE_LINE(PL), .REARM_LINE(RL), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ys(ys),
    .snes_refresh(snes_refresh), .hdmi_frame_start(hdmi_frame_start),
    .pause_snes(pause_snes), .sync_locked(sync_locked),
    .pause_len(pause_len), .timeout_count(timeout_count)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_armed = 1'b0; m_halted = 1'b0; m_locked = 1'b0;
    m_edge = 0; m_start = 0; m_len = 0; m_tcnt = 0;
    hist.delete();
    repeat (S + 1) hist.push_back(1'b0);
  endtask

  // advance the model by one clock edge using the inputs held across it
  task automatic model_edge();
    bit rise;
    int held;
    m_edge++;
    hist.push_back(hdmi_frame_start);
    if (hist.size() > S + 2) void'(hist.pop_front());
    rise = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
    if (!enable) begin
      m_active = 1'b0; m_armed = 1'b0; m_halted = 1'b0; m_locked = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_armed = 1'b1;
    end else if (m_halted) begin
      held = m_edge - m_start;
      if (rise) begin
        m_halted = 1'b0; m_len = held; m_locked = 1'b1;
      end else if (held == T) begin
        m_halted = 1'b0; m_len = T; m_locked = 1'b0;
        if (m_tcnt < 255) m_tcnt++;
      end
    end else if (m_armed) begin
      if (ys[7:0] == 8'(PL) && snes_refresh) begin
        m_armed = 1'b0; m_halted = 1'b1; m_start = m_edge;
      end
    end else begin
      if (ys[7:0] == 8'(RL)) m_armed = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("pause_snes", 32'(pause_snes), 32'(m_halted));
    check("sync_locked", 32'(sync_locked), 32'(m_locked));
    check("pause_len", 32'(pause_len), 32'(m_len));
    check("timeout_count", 32'(timeout_count), 32'(m_tcnt));
  endtask

  // one clock: model at the edge, compare at the following falling edge
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [8:0] y, input logic rf);
    ys = y;
    snes_refresh = rf;
  endtask

  int hold;

  initial begin
    reset = 1'b1; enable = 1'b1; ys = 9'd2; snes_refresh = 1'b1; hdmi_frame_start = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("rst_pause_low", 32'(pause_snes), 32'd0);
    reset = 1'b0;
    cycle();
    check("armed_no_pause_yet", 32'(pause_snes), 32'd0);
    cycle();
    check("pause_after_arm", 32'(pause_snes), 32'd1);

    // HDMI release: sampled high 40 edges after the pause edge
    drive(9'd50, 1'b0);
    repeat (39) cycle();
    hdmi_frame_start = 1'b1;
    repeat (2) cycle();
    check("release_not_early", 32'(pause_snes), 32'd1);
    cycle();
    check("rel_pause", 32'(pause_snes), 32'd0);
    check("rel_len42", 32'(pause_len), 32'd42);
    check("rel_locked", 32'(sync_locked), 32'd1);
    check("rel_tcnt0", 32'(timeout_count), 32'd0);
    hdmi_frame_start = 1'b0;
    cycle();

    // timeout with no HDMI edge
    drive(9'(RL), 1'b0); cycle();
    drive(9'(PL), 1'b1); cycle();
    drive(9'd0, 1'b0);
    repeat (T - 1) cycle();
    check("to_still_high", 32'(pause_snes), 32'd1);
    cycle();
    check("to_pause", 32'(pause_snes), 32'd0);
    check("to_len", 32'(pause_len), 32'(T));
    check("to_locked", 32'(sync_locked), 32'd0);
    check("to_tcnt1", 32'(timeout_count), 32'd1);

    // stale HDMI edge in RUN must not release the next pause
    drive(9'd150, 1'b0);
    hdmi_frame_start = 1'b1; repeat (3) cycle();
    hdmi_frame_start = 1'b0; repeat (3) cycle();
    drive(9'(RL), 1'b0); cycle();
    drive(9'(PL), 1'b1); cycle();
    drive(9'd0, 1'b0);
    repeat (50) cycle();
    check("stale_hold", 32'(pause_snes), 32'd1);
    hdmi_frame_start = 1'b1; repeat (3) cycle();
    check("fresh_len53", 32'(pause_len), 32'd53);
    check("fresh_locked", 32'(sync_locked), 32'd1);
    hdmi_frame_start = 1'b0; cycle();

    // disable in the middle of a pause
    drive(9'(RL), 1'b0); cycle();
    drive(9'(PL), 1'b1); cycle();
    drive(9'd0, 1'b0);
    repeat (10) cycle();
    enable = 1'b0; cycle();
    check("dis_pause", 32'(pause_snes), 32'd0);
    check("dis_locked", 32'(sync_locked), 32'd0);
    check("dis_len_held", 32'(pause_len), 32'd53);
    enable = 1'b1; cycle();

    // HDMI edge and timeout coincide: the HDMI edge wins
    drive(9'(PL), 1'b1); cycle();
    drive(9'd0, 1'b0);
    repeat (T - 3) cycle();
    hdmi_frame_start = 1'b1; repeat (3) cycle();
    check("tie_locked", 32'(sync_locked), 32'd1);
    check("tie_len", 32'(pause_len), 32'(T));
    check("tie_tcnt", 32'(timeout_count), 32'd1);
    hdmi_frame_start = 1'b0; cycle();

    // 300 timed-out frames saturate the timeout counter
    for (int f = 0; f < 300; f++) begin
      drive(9'(RL), 1'b1); cycle();
      drive(9'(PL), 1'b1); cycle();
      drive(9'd0, 1'b0);
      for (int w = 0; w < T + 20 && m_halted; w++) cycle();
    end
    check("tcnt_saturated", 32'(timeout_count), 32'd255);

    // asynchronous reset in the middle of a pause
    drive(9'(RL), 1'b0); cycle();
    drive(9'(PL), 1'b1); cycle();
    drive(9'd0, 1'b0);
    repeat (5) cycle();
    check("mid_pause_high", 32'(pause_snes), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_drop", 32'(pause_snes), 32'd0);
    model_reset();
    @(negedge clk);
    repeat (2) cycle();
    reset = 1'b0;

    // randomized phase
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (hold > 0) hold--;
      else if ($urandom_range(0, 49) == 0) begin
        hdmi_frame_start = ~hdmi_frame_start;
        hold = $urandom_range(1, 5);
      end
      r = $urandom_range(0, 9);
      if (r < 4) ys = {1'($urandom_range(0, 1)), 8'(PL)};
      else if (r < 6) ys = {1'($urandom_range(0, 1)), 8'(RL)};
      else ys = 9'($urandom_range(0, 511));
      snes_refresh = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
